// File: rtl/reg_bus_pkg.sv
// Shared types for the register bus initiator.
// FSM encoding, command entry sizing and counter width.
package reg_bus_pkg;

  localparam int TXN_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Entry layout is {write bit, address, wdata}
  function automatic int entry_width(
    input int aw,
    input int dw
  );
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/reg_bus_cmd_fifo.sv
// Single-clock command FIFO with wrap-bit pointers.
// Push is refused when full, even if a pop happens in the same cycle.
module reg_bus_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_d = do_push ? wr_q + ONE : wr_q;
  assign rd_d = do_pop  ? rd_q + ONE : rd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

  assign dout = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/reg_bus_master.sv
// Register bus initiator: queues commands, runs them one at a time,
// returns read data over a valid/ready response port.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 33,
  parameter int WDATA_WIDTH = 33,
  parameter int RDATA_WIDTH = 21,
  parameter int CMD_DEPTH   = 4,
  parameter int READ_WAIT   = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [WDATA_WIDTH-1:0]     cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RDATA_WIDTH-1:0]     rsp_rdata,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic                       write_enable,
  output logic [WDATA_WIDTH-1:0]     write_data,
  output logic                       read_enable,
  input  logic [RDATA_WIDTH-1:0]     read_data,
  output logic                       busy,
  output logic [TXN_COUNT_WIDTH-1:0] txn_count
);

  localparam int EW = entry_width(ADDR_WIDTH, WDATA_WIDTH);
  localparam logic [3:0] RW = 4'(READ_WAIT);

  state_e state_q, state_d;

  logic [3:0]                 wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [WDATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                       we_q, we_d;
  logic                       re_q, re_d;
  logic                       rvld_q, rvld_d;
  logic [RDATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [TXN_COUNT_WIDTH-1:0] txn_q, txn_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [EW-1:0]          fifo_din;
  logic [EW-1:0]          fifo_dout;
  logic                   head_write;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [WDATA_WIDTH-1:0] head_wdata;

  assign fifo_din = {cmd_write, cmd_addr, cmd_wdata};

  reg_bus_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_write = fifo_dout[EW-1];
  assign head_addr  = fifo_dout[EW-2 -: ADDR_WIDTH];
  assign head_wdata = fifo_dout[WDATA_WIDTH-1:0];

  // Strobes and bus fields default low so they are 0 between transfers
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_d   = '0;
    wdata_d  = '0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    rvld_d   = rvld_q;
    rdata_d  = rdata_q;
    txn_d    = txn_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          wait_d   = '0;
          if (head_write) begin
            we_d    = 1'b1;
            wdata_d = head_wdata;
            state_d = WRITE;
          end else begin
            re_d    = 1'b1;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        txn_d   = txn_q + 1'b1;
        state_d = IDLE;
      end
      READ: begin
        if (wait_q == RW) begin
          rvld_d  = 1'b1;
          rdata_d = read_data;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
          re_d   = 1'b1;
          addr_d = addr_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvld_d  = 1'b0;
          txn_d   = txn_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      txn_q   <= txn_d;
    end
  end

  assign cmd_ready    = !fifo_full;
  assign address      = addr_q;
  assign write_enable = we_q;
  assign write_data   = wdata_q;
  assign read_enable  = re_q;
  assign rsp_valid    = rvld_q;
  assign rsp_rdata    = rdata_q;
  assign txn_count    = txn_q;
  assign busy         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: random and directed commands
// checked against a transaction-level queue model.
module tb_reg_bus_master;

  localparam int AW    = 33;
  localparam int DW    = 33;
  localparam int RDW   = 21;
  localparam int DEPTH = 4;
  localparam int RWAIT = 1;

  logic           clock;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [RDW-1:0] rsp_rdata;
  logic [AW-1:0]  address;
  logic           write_enable;
  logic [DW-1:0]  write_data;
  logic           read_enable;
  logic [RDW-1:0] read_data;
  logic           busy;
  logic [15:0]    txn_count;
  logic [RDW-1:0] rd_xor;

  reg_bus_master #(
    .ADDR_WIDTH  (AW),
    .WDATA_WIDTH (DW),
    .RDATA_WIDTH (RDW),
    .CMD_DEPTH   (DEPTH),
    .READ_WAIT   (RWAIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .address      (address),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .busy         (busy),
    .txn_count    (txn_count)
  );

  // Responder: data is a simple function of the address
  assign read_data = address[RDW-1:0] ^ rd_xor;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t           exp_q[$];
  logic [RDW-1:0] rsp_q[$];
  int             vec;
  int             miss;
  int             mdl_txn;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [32:0] rnd33();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[32:0];
  endfunction

  // Bus monitor: ordering, strobe shape and response data
  initial begin : mon
    cmd_t        c;
    logic        pwe;
    logic        pre;
    int          rlen;
    logic [AW-1:0] raddr;
    pwe = 0; pre = 0; rlen = 0; raddr = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pwe = 0; pre = 0; rlen = 0;
        exp_q.delete();
        rsp_q.delete();
      end else begin
        vec++;
        if (write_enable && read_enable) begin
          miss++;
          $display("FAIL strobe_overlap we=%0b re=%0b want not both",
                   write_enable, read_enable);
        end
        if (!write_enable && !read_enable) begin
          vec++;
          if (address !== '0 || write_data !== '0) begin
            miss++;
            $display("FAIL idle_bus addr=%0h wdata=%0h want 0",
                     address, write_data);
          end
          if (pre) begin
            vec++;
            if (rlen != RWAIT + 1) begin
              miss++;
              $display("FAIL read_len got %0d want %0d",
                       rlen, RWAIT + 1);
            end
          end
        end
        if (write_enable) begin
          vec++;
          if (pwe || pre) begin
            miss++;
            $display("FAIL write_gap pwe=%0b pre=%0b want 0", pwe, pre);
          end
          vec++;
          if (exp_q.size() == 0) begin
            miss++;
            $display("FAIL stray_write addr=%0h want none", address);
          end else begin
            c = exp_q.pop_front();
            if (!c.w || address !== c.a || write_data !== c.d) begin
              miss++;
              $display("FAIL write_txn got w=1 a=%0h d=%0h want w=%0b a=%0h d=%0h",
                       address, write_data, c.w, c.a, c.d);
            end
            mdl_txn++;
          end
        end
        if (read_enable && !pre) begin
          vec++;
          if (pwe) begin
            miss++;
            $display("FAIL read_gap pwe=%0b want 0", pwe);
          end
          vec++;
          if (exp_q.size() == 0) begin
            miss++;
            $display("FAIL stray_read addr=%0h want none", address);
          end else begin
            c = exp_q.pop_front();
            if (c.w || address !== c.a || write_data !== '0) begin
              miss++;
              $display("FAIL read_txn got a=%0h d=%0h want w=%0b a=%0h d=0",
                       address, write_data, c.w, c.a);
            end
            rsp_q.push_back(c.a[RDW-1:0] ^ rd_xor);
            raddr = c.a;
          end
          rlen = 1;
        end else if (read_enable) begin
          rlen++;
          vec++;
          if (address !== raddr) begin
            miss++;
            $display("FAIL read_addr_hold got %0h want %0h", address, raddr);
          end
        end
        if (rsp_valid) begin
          vec++;
          if (rsp_q.size() == 0) begin
            miss++;
            $display("FAIL stray_rsp rdata=%0h want none", rsp_rdata);
          end else begin
            if (rsp_rdata !== rsp_q[0]) begin
              miss++;
              $display("FAIL rsp_rdata got %0h want %0h", rsp_rdata, rsp_q[0]);
            end
            if (rsp_ready) begin
              void'(rsp_q.pop_front());
              mdl_txn++;
            end
          end
        end
        pwe = write_enable;
        pre = read_enable;
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    cmd_t c;
    bit   ok;
    ok = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int k = 0; k < 100; k++) begin
      if (cmd_ready) begin
        c.w = w; c.a = a; c.d = w ? d : '0;
        exp_q.push_back(c);
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL accept_timeout got ready=0 want accept");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (!busy && !rsp_valid && exp_q.size() == 0 &&
          rsp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL drain_timeout busy=%0b pend=%0d want idle",
               busy, exp_q.size());
    end
    vec++;
    if (txn_count !== 16'(mdl_txn)) begin
      miss++;
      $display("FAIL txn_count got %0d want %0d", txn_count, mdl_txn);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vec++;
    if ({address, write_enable, write_data, read_enable, rsp_valid,
         rsp_rdata, busy, txn_count} !== '0) begin
      miss++;
      $display("FAIL reset_outs got nonzero want 0 (a=%0h we=%0b re=%0b rv=%0b busy=%0b txn=%0d)",
               address, write_enable, read_enable, rsp_valid, busy, txn_count);
    end
    vec++;
    if (cmd_ready !== 1'b1) begin
      miss++;
      $display("FAIL reset_ready got %0b want 1", cmd_ready);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    send(1'b1, 33'hAA, 33'h1234);
    tick();
    vec++;
    if (write_enable !== 1'b1 || address !== 33'hAA ||
        write_data !== 33'h1234) begin
      miss++;
      $display("FAIL wr_strobe got we=%0b a=%0h d=%0h want 1 aa 1234",
               write_enable, address, write_data);
    end
    tick();
    vec++;
    if (write_enable !== 1'b0 || txn_count !== 16'd1 ||
        rsp_valid !== 1'b0) begin
      miss++;
      $display("FAIL wr_after got we=%0b txn=%0d rv=%0b want 0 1 0",
               write_enable, txn_count, rsp_valid);
    end
  endtask

  task automatic test_read_hold();
    rsp_ready = 1'b0;
    rd_xor = 21'h54;
    send(1'b0, 33'h55, rnd33());
    for (int i = 0; i <= RWAIT; i++) begin
      tick();
      vec++;
      if (read_enable !== 1'b1 || rsp_valid !== 1'b0) begin
        miss++;
        $display("FAIL rd_strobe cyc%0d got re=%0b rv=%0b want 1 0",
                 i, read_enable, rsp_valid);
      end
    end
    tick();
    vec++;
    if (read_enable !== 1'b0 || rsp_valid !== 1'b1 ||
        rsp_rdata !== 21'h1) begin
      miss++;
      $display("FAIL rd_rsp got re=%0b rv=%0b d=%0h want 0 1 1",
               read_enable, rsp_valid, rsp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 21'h1 ||
          txn_count !== 16'd1) begin
        miss++;
        $display("FAIL rsp_hold cyc%0d got rv=%0b d=%0h txn=%0d want 1 1 1",
                 i, rsp_valid, rsp_rdata, txn_count);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec++;
    if (rsp_valid !== 1'b0 || txn_count !== 16'd2) begin
      miss++;
      $display("FAIL rsp_handshake got rv=%0b txn=%0d want 0 2",
               rsp_valid, txn_count);
    end
  endtask

  task automatic test_fifo_full();
    cmd_t c;
    bit   ok;
    rsp_ready = 1'b0;
    rd_xor = 21'($urandom());
    send(1'b0, rnd33(), rnd33());
    repeat (RWAIT + 2) tick();
    vec++;
    if (rsp_valid !== 1'b1) begin
      miss++;
      $display("FAIL stall_resp got rv=%0b want 1", rsp_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, rnd33(), rnd33());
    end
    vec++;
    if (cmd_ready !== 1'b0) begin
      miss++;
      $display("FAIL full_ready got %0b want 0", cmd_ready);
    end
    c.w = 1'b1; c.a = rnd33(); c.d = rnd33();
    cmd_valid = 1'b1;
    cmd_write = c.w;
    cmd_addr  = c.a;
    cmd_wdata = c.d;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (cmd_ready !== 1'b0) begin
        miss++;
        $display("FAIL full_hold cyc%0d got ready=%0b want 0", i, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready) begin
        exp_q.push_back(c);
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL fifth_accept got ready=0 want accept");
    end
    drain();
  endtask

  task automatic test_alternating();
    int t0;
    t0 = mdl_txn;
    rsp_ready = 1'b1;
    rd_xor = 21'($urandom());
    for (int i = 0; i < 8; i++) begin
      send(i[0] == 1'b0, rnd33(), rnd33());
    end
    drain();
    vec++;
    if (txn_count !== 16'(t0 + 8)) begin
      miss++;
      $display("FAIL alt_count got %0d want %0d", txn_count, t0 + 8);
    end
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    rd_xor = 21'($urandom());
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(1'($urandom_range(0, 1)), rnd33(), rnd33());
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1;
      end
      begin
        while (!done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_mid_read();
    rsp_ready = 1'b0;
    send(1'b0, rnd33(), rnd33());
    tick();
    vec++;
    if (read_enable !== 1'b1) begin
      miss++;
      $display("FAIL pre_reset_read got re=%0b want 1", read_enable);
    end
    #2;
    reset = 1'b0;
    mdl_txn = 0;
    #1;
    vec++;
    if ({address, write_enable, write_data, read_enable, rsp_valid,
         rsp_rdata, busy, txn_count} !== '0 || cmd_ready !== 1'b1) begin
      miss++;
      $display("FAIL mid_reset got re=%0b busy=%0b txn=%0d ready=%0b want 0 0 0 1",
               read_enable, busy, txn_count, cmd_ready);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vec++;
      if (read_enable !== 1'b0 || busy !== 1'b0) begin
        miss++;
        $display("FAIL post_reset cyc%0d got re=%0b busy=%0b want 0 0",
                 i, read_enable, busy);
      end
    end
    send(1'b1, rnd33(), rnd33());
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec       = 0;
    miss      = 0;
    mdl_txn   = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    rd_xor    = '0;
    test_reset();
    test_single_write();
    test_read_hold();
    test_fifo_full();
    test_alternating();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
